// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the scoreboarded register file.
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NUM_RD = 3;
  localparam int DEF_NUM_WR = 2;

  localparam int REG_ZERO = 0;

  // Low bit of element idx inside a packed bus of w-bit elements.
  function automatic int slice_lo(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/regfile_bypass_mux.sv
// Per-read-port write-to-read bypass: the highest-index enabled write port
// whose full address equals the nonzero read address supplies the data.
module regfile_bypass_mux
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_WR = DEF_NUM_WR
) (
  input  logic [ADDR_W-1:0]        addr,
  input  logic [DATA_W-1:0]        stored,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0]        data,
  output logic                     hit
);

  // NOTE: every output of a combinational block gets a default first so no
  // path through the loop can leave it unassigned and infer a latch.
  always_comb begin
    data = stored;
    hit  = 1'b0;
    for (int i = 0; i < NUM_WR; i++) begin
      if (wr_en[i] && addr != ADDR_W'(REG_ZERO) &&
          wr_addr[slice_lo(i, ADDR_W) +: ADDR_W] == addr) begin
        data = wr_data[slice_lo(i, DATA_W) +: DATA_W];
        hit  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with per-register busy scoreboard.
// Optional REGFILE_SB_WR_CONFLICT_EN adds a sticky same-address write flag.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = DEF_NUM_RD,
  parameter int NUM_WR = DEF_NUM_WR
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic [2**ADDR_W-1:0]     busy_vec
`ifdef REGFILE_SB_WR_CONFLICT_EN
  ,
  output logic                     err_wr_conflict
`endif
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_next;

  // NOTE: the storage array is cleared on reset because software relies on
  // all registers reading 0 afterwards; this costs a reset net per flop.
  // Within the write loop the later non-blocking assignment to the same
  // entry wins, which gives the higher-index port priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < DEPTH; r++) regs[r] <= '0;
    end else begin
      for (int i = 0; i < NUM_WR; i++) begin
        if (wr_en[i] && wr_addr[slice_lo(i, ADDR_W) +: ADDR_W] != ADDR_W'(REG_ZERO))
          regs[wr_addr[slice_lo(i, ADDR_W) +: ADDR_W]] <= wr_data[slice_lo(i, DATA_W) +: DATA_W];
      end
    end
  end

  // Write-back clears first so a same-cycle issue to that register re-sets it.
  always_comb begin
    busy_next = busy;
    for (int i = 0; i < NUM_WR; i++) begin
      if (wr_en[i]) busy_next[wr_addr[slice_lo(i, ADDR_W) +: ADDR_W]] = 1'b0;
    end
    if (iss_en) busy_next[iss_addr] = 1'b1;
    busy_next[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= busy_next;
  end

  assign busy_vec = busy;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              hit;

    assign addr = rd_addr[slice_lo(k, ADDR_W) +: ADDR_W];

    regfile_bypass_mux #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .NUM_WR (NUM_WR)
    ) u_mux (
      .addr    (addr),
      .stored  (regs[addr]),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .data    (data),
      .hit     (hit)
    );

    // A write-back this cycle resolves the stall; data arrives via bypass.
    assign rd_data[slice_lo(k, DATA_W) +: DATA_W] = rst ? '0 : data;
    assign rd_busy[k] = !rst && busy[addr] && !hit;
  end

`ifdef REGFILE_SB_WR_CONFLICT_EN
  logic conflict;

  always_comb begin
    conflict = 1'b0;
    for (int i = 0; i < NUM_WR; i++) begin
      for (int j = i + 1; j < NUM_WR; j++) begin
        if (wr_en[i] && wr_en[j] &&
            wr_addr[slice_lo(i, ADDR_W) +: ADDR_W] == wr_addr[slice_lo(j, ADDR_W) +: ADDR_W] &&
            wr_addr[slice_lo(i, ADDR_W) +: ADDR_W] != ADDR_W'(REG_ZERO))
          conflict = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)           err_wr_conflict <= 1'b0;
    else if (conflict) err_wr_conflict <= 1'b1;
  end
`endif

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised multi-port general-purpose register file with a per-register busy scoreboard. Successor to the 3-read/1-write ID-stage register file.
- Adds configurable width, depth and port counts, and multiple write-back ports with fixed priority.
- Corrects full-address write-to-read bypass.
- Tracks in-flight producers so the ID stage can stall on RAW hazards in the multi-cycle and overlapped pipeline.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width; depth = 2**ADDR_W.
- NUM_RD, 3, number of read ports.
- NUM_WR, 2, number of write ports; a higher index has higher priority.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- wr_en  in  NUM_WR  per-port write enable.
- wr_addr  in  NUM_WR*ADDR_W  write addresses; port i occupies bits [i*ADDR_W +: ADDR_W].
- wr_data  in  NUM_WR*DATA_W  write data, packed the same way.
- rd_addr  in  NUM_RD*ADDR_W  read addresses, packed.
- rd_data  out  NUM_RD*DATA_W  read data, combinational.
- rd_busy  out  NUM_RD  1 = the source register has a pending producer; ID must stall.
- iss_en  in  1  issue: mark the destination register busy.
- iss_addr  in  ADDR_W  destination register of the issuing instruction.
- busy_vec  out  2**ADDR_W  raw scoreboard bits, for debug and the hazard unit.

Behaviour:
- Register 0:
  - Always reads 0.
  - Writes to it are dropped.
  - It is never marked busy.
  - It is never bypassed.
- Reset (rst=1 at a clk edge):
  - All registers and all busy bits become 0.
  - Reset overrides any write or issue in the same cycle.
  - While rst=1: rd_data=0, rd_busy=0, bypass is disabled.
  - busy_vec shows the stored bits (all 0 after the first reset edge).
- Write:
  - On a clk edge, every port i with wr_en[i]=1 and wr_addr!=0 writes wr_data into the register.
  - If two or more ports target the same address, the highest-index port's data is stored.
  - Write latency: the value is in storage from the next cycle on.
- Read and bypass (combinational, zero latency):
  - For each read port, rd_data is the wr_data of the highest-index port with wr_en=1 and wr_addr == rd_addr (full ADDR_W equality, rd_addr!=0).
  - If no port matches, rd_data is the stored value.
- Scoreboard busy[r]:
  - Set at the clk edge when iss_en=1 and iss_addr=r!=0.
  - Cleared at the clk edge when any enabled write port targets r.
  - If an issue and a write to the same r occur in one cycle, the issue wins and busy stays 1 (a new producer has overwritten the old one).
  - An issue to a register that is already busy is legal; busy stays 1. There is no producer counting; in-order write-back is guaranteed by the pipeline.
- rd_busy[k]:
  - Equals busy[rd_addr_k] AND NOT (any enabled write to rd_addr_k this cycle).
  - So a write-back resolves the stall in the same cycle, with data supplied via bypass.
  - The same-cycle iss_en does NOT affect rd_busy; the issuing instruction is not its own consumer.
  - rd_busy is 0 for address 0.
- Reset mid-operation: all pending producers are forgotten. The pipeline flush is the caller's responsibility.

Optional Feature:
- Macro: REGFILE_SB_WR_CONFLICT_EN.
- Defined:
  - Adds output port err_wr_conflict (1 bit, registered).
  - It is set at a clk edge when two or more write ports are enabled with the same nonzero address. It is sticky until rst.
  - Reset value 0.
  - The write still resolves by priority.
- Undefined: the port and its logic are absent. Priority resolution is unchanged.

Decomposition:
- Package regfile_pkg holds:
  - Default DATA_W, ADDR_W, NUM_RD, NUM_WR.
  - Constant REG_ZERO = 0.
  - A helper function for packed-slice indexing.
- Sub-module regfile_bypass_mux, instantiated once per read port:
  - Inputs: one read address, the stored value, and all write-port enables, addresses and data.
  - Outputs: the priority-resolved data and a write-hit flag (used for rd_busy).
- The top level holds the storage array, the scoreboard and the conflict flag.

Test Plan:
- Reset then read: assert rst 1 cycle, read r1..r31 -> all rd_data=0, busy_vec=0; write r5=0xDEADBEEF during rst -> r5 still reads 0.
- Bypass: write r3=0x12345678 on port 0 while rd_addr0=r3 and rd_addr1=r2 -> rd_data0=0x12345678 in the same cycle, rd_data1 = stored r2 (checks full address compare, since 3&2!=0).
- Priority: port0 writes r7=0x1, port1 writes r7=0x2 in the same cycle -> bypass and the next-cycle read both give 0x2; err_wr_conflict=1 when the macro is defined.
- Scoreboard: issue r9 -> busy_vec[9]=1 next cycle, rd_busy=1 for a reader of r9; write-back r9=0xAA -> rd_busy=0 that same cycle with rd_data=0xAA, busy_vec[9]=0 next cycle.
- Issue/write collision: iss_en r4 and write r4 in the same cycle -> busy_vec[4] stays 1; r4 holds the written data.
- Zero register: write r0=0xFFFFFFFF and issue r0 -> r0 reads 0, busy_vec[0]=0, rd_busy=0, no bypass of 0xFFFFFFFF.
